// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl
//   Takes decoded uops, holds them in a 2-entry in-order FIFO and writes each one
//   to the memory queue or the ALU queue. Branches (i_pry == 11) get a one-hot
//   tag from a small tag pool. Every uop also carries the mask of tags that
//   were still unresolved when it was accepted. A mispredict flushes the FIFO
//   and the tag pool, then holds off dispatch for one cycle.
//
// Ports
//   i_clk, i_rst_n          clock; asynchronous active-low reset
//   i_valid/i_queue/i_pry   decoder handshake, target queue (01 MEM, 10 ALU,
//   i_uop                   anything else dropped), priority and payload
//   o_ready                 dispatch can take i_valid this cycle
//   i_memq_full/i_aluq_full the target queue cannot take a write
//   o_memq_we/o_aluq_we     one-cycle write strobes
//   o_uop/o_brtag/o_brmask  payload, branch tag and dependency mask of the head
//   i_br_done/i_br_tag      a branch resolved; its tag is freed
//   i_mispredict            flush all speculative state
module dispatch_ctrl #(
   parameter int WIDTH_UOP = 64,
   parameter int NBR       = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   input  logic [1:0]           i_queue,
   input  logic [1:0]           i_pry,
   input  logic [WIDTH_UOP-1:0] i_uop,
   output logic                 o_ready,
   input  logic                 i_memq_full,
   input  logic                 i_aluq_full,
   output logic                 o_memq_we,
   output logic                 o_aluq_we,
   output logic [WIDTH_UOP-1:0] o_uop,
   output logic [NBR-1:0]       o_brtag,
   output logic [NBR-1:0]       o_brmask,
   input  logic                 i_br_done,
   input  logic [NBR-1:0]       i_br_tag,
   input  logic                 i_mispredict
);

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

   typedef struct packed {
      logic [WIDTH_UOP-1:0] uop;
      logic                 is_mem;
      logic                 br;
      logic [NBR-1:0]       tag;
      logic [NBR-1:0]       mask;
   } entry_t;

   state_t              state_q, state_d;
   entry_t [1:0]        ent_q, ent_d, held;
   entry_t              new_ent, head;
   logic   [1:0]        cnt_q, cnt_d;
   logic   [NBR-1:0]    busy_q, busy_d;
   logic   [NBR-1:0]    done_mask, free_vec, alloc_tag;
   logic                rdy_en_q;
   logic                in_br, in_enq, acc, issue, head_full;

   // Holds o_ready low while reset is asserted. It rises on the first edge
   // after reset is released.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) rdy_en_q <= 1'b0;
      else          rdy_en_q <= 1'b1;
   end

   always_comb begin
      done_mask = i_br_done ? i_br_tag : '0;
      free_vec  = ~busy_q;
      // Isolate the lowest set bit of the free vector: this is the lowest free tag.
      alloc_tag = free_vec & (~free_vec + NBR'(1));
      in_br     = (i_pry == 2'b11);
      in_enq    = (i_queue == 2'b01) || (i_queue == 2'b10);
      // A tag freed in this cycle is not visible until the next cycle. This keeps
      // the tag from being handed out again in the cycle that frees it.
      o_ready   = rdy_en_q && (state_q == RUN) && (cnt_q != 2'd2) &&
                  (!in_br || (|free_vec));
      acc       = i_valid && o_ready && in_enq && !i_mispredict;

      head      = ent_q[0];
      head_full = head.is_mem ? i_memq_full : i_aluq_full;
      issue     = (cnt_q != 2'd0) && (state_q == RUN) && !i_mispredict && !head_full;
      o_memq_we = issue && head.is_mem;
      o_aluq_we = issue && !head.is_mem;
      o_uop     = head.uop;
      o_brtag   = (issue && head.br) ? head.tag : '0;
      // The mask leaving the block already excludes a tag resolved in this cycle.
      o_brmask  = issue ? (head.mask & ~done_mask) : '0;
   end

   always_comb begin
      new_ent.uop    = i_uop;
      new_ent.is_mem = (i_queue == 2'b01);
      new_ent.br     = in_br;
      new_ent.tag    = in_br ? alloc_tag : '0;
      new_ent.mask   = busy_q & ~done_mask;

      held = ent_q;
      for (int i = 0; i < 2; i++) held[i].mask = ent_q[i].mask & ~done_mask;

      ent_d   = held;
      cnt_d   = cnt_q;
      // The tag is cleared first, then set. If the same tag is resolved and
      // allocated in one cycle, the allocation wins.
      busy_d  = (busy_q & ~done_mask) | ((acc && in_br) ? alloc_tag : '0);
      state_d = RUN;

      if (issue) begin
         ent_d[0] = held[1];
         cnt_d    = cnt_q - 2'd1;
      end
      if (acc) begin
         ent_d[cnt_d[0]] = new_ent;
         cnt_d           = cnt_d + 2'd1;
      end
      if (i_mispredict) begin
         state_d = FLUSH;
         cnt_d   = 2'd0;
         busy_d  = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= RUN;
         ent_q   <= '0;
         cnt_q   <= 2'd0;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         ent_q   <= ent_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

endmodule
